// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Brief    : MEM-stage load/store unit. Runs a req/ack transaction with data
//            memory, stalls the pipeline front, extends loads, flags errors.
//            Optional feature macro: LSU_MISALIGN_TRAP_EN
// Revision : 1.0
// ============================================================================
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        readm,
    input  logic        memWrtm,
    input  logic [2:0]  funct3m,
    input  logic [31:0] aluRsltm,
    input  logic [31:0] wrtDm,
    output logic        stallm,
    output logic [31:0] loadDm,
    output logic        loadVldm,
    output logic        busErrm,
    output logic        misalignm,
    output logic        dReq,
    output logic        dWe,
    output logic [31:0] dAddr,
    output logic [31:0] dWdata,
    output logic [3:0]  dBe,
    input  logic        dAck,
    input  logic        dErr,
    input  logic [31:0] dRdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]  r_state, w_next;
    logic [7:0]  r_cnt;
    logic        r_is_load, r_err, r_dreq, r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_addr, r_wdata, r_ldata;
    logic [3:0]  r_be;
    logic        w_acc, w_trap, w_timeout, w_mis;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_acc     = readm | memWrtm;
    assign w_timeout = (r_cnt == C_CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_mis;
    // funct3[1]=1 covers W and the reserved codes that behave as W
    assign w_trap = w_acc & (((funct3m[1:0] == 2'b01) & aluRsltm[0]) |
                             (funct3m[1] & (aluRsltm[1:0] != 2'b00)));
    assign w_mis  = r_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mis <= 1'b0;
        else if (r_state == S_IDLE && w_acc)
            r_mis <= w_trap;
    end
`else
    assign w_trap = 1'b0;
    assign w_mis  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_acc) w_next = w_trap ? S_DONE : S_BUSY;
            S_BUSY:  if (dErr || dAck || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Store lane placement from the incoming access
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wrtDm;
        case (funct3m[1:0])
            2'b00: begin
                w_be    = 4'b0001 << aluRsltm[1:0];
                w_wdata = {4{wrtDm[7:0]}};
            end
            2'b01: begin
                w_be    = aluRsltm[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wrtDm[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction from the captured offset and size
    always_comb begin
        case (r_off)
            2'd0:    w_byte = dRdata[7:0];
            2'd1:    w_byte = dRdata[15:8];
            2'd2:    w_byte = dRdata[23:16];
            default: w_byte = dRdata[31:24];
        endcase
        w_half = r_off[1] ? dRdata[31:16] : dRdata[15:0];
        case (r_funct3[1:0])
            2'b00:   w_ext = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            default: w_ext = dRdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 8'd0;
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
            r_dreq    <= 1'b0;
            r_we      <= 1'b0;
            r_funct3  <= 3'd0;
            r_off     <= 2'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_ldata   <= 32'd0;
            r_be      <= 4'd0;
        end else begin
            r_dreq <= (w_next == S_BUSY);
            if (r_state == S_IDLE && w_acc) begin
                r_cnt     <= 8'd0;
                r_is_load <= ~memWrtm;
                r_we      <= memWrtm;
                r_err     <= 1'b0;
                r_funct3  <= funct3m;
                r_off     <= aluRsltm[1:0];
                r_addr    <= {aluRsltm[31:2], 2'b00};
                r_wdata   <= w_wdata;
                r_be      <= w_be;
                r_ldata   <= 32'd0;
            end else if (r_state == S_BUSY) begin
                // dErr outranks dAck so a faulted read never returns data
                if (dErr || (!dAck && w_timeout)) begin
                    r_err   <= 1'b1;
                    r_ldata <= 32'd0;
                end else if (dAck) begin
                    r_ldata <= w_ext;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    // Output decode; stall is masked during reset so all outputs read 0
    always_comb begin
        stallm    = 1'b0;
        loadVldm  = 1'b0;
        busErrm   = 1'b0;
        loadDm    = 32'd0;
        misalignm = 1'b0;
        case (r_state)
            S_IDLE: stallm = rst_n & w_acc;
            S_BUSY: stallm = 1'b1;
            S_DONE: begin
                loadVldm  = r_is_load & ~w_mis;
                busErrm   = r_err;
                loadDm    = (r_is_load & ~w_mis) ? r_ldata : 32'd0;
                misalignm = w_mis;
            end
            default: ;
        endcase
    end

    assign dReq   = r_dreq;
    assign dWe    = r_we;
    assign dAddr  = r_addr;
    assign dWdata = r_wdata;
    assign dBe    = r_be;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// tb_mem_lsu : directed and randomized accesses against a behavioural model
// of the load/store unit, with a short bus timeout.
module tb_mem_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        readm = 1'b0, memWrtm = 1'b0;
    logic [2:0]  funct3m = 3'd0;
    logic [31:0] aluRsltm = 32'd0, wrtDm = 32'd0;
    logic        stallm, loadVldm, busErrm, misalignm, dReq, dWe;
    logic [31:0] loadDm, dAddr, dWdata;
    logic [3:0]  dBe;
    logic        dAck = 1'b0, dErr = 1'b0;
    logic [31:0] dRdata = 32'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .readm(readm), .memWrtm(memWrtm),
        .funct3m(funct3m), .aluRsltm(aluRsltm), .wrtDm(wrtDm),
        .stallm(stallm), .loadDm(loadDm), .loadVldm(loadVldm),
        .busErrm(busErrm), .misalignm(misalignm), .dReq(dReq), .dWe(dWe),
        .dAddr(dAddr), .dWdata(dWdata), .dBe(dBe), .dAck(dAck), .dErr(dErr),
        .dRdata(dRdata)
    );

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int sz = size_of(f3);
        int lane;
        longint unsigned r, v;
        bit sgn = (f3 == 3'b000) || (f3 == 3'b001);
        if (sz == 4) return rd;
        lane = (int'(a % 4) / sz) * sz;
        r = 64'(rd);
        v = (r >> (8 * lane)) % (64'd1 << (8 * sz));
        if (sgn && v >= (64'd1 << (8 * sz - 1)))
            v = v + 64'h1_0000_0000 - (64'd1 << (8 * sz));
        return 32'(v);
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        if (sz == 1) return 4'(1 << int'(a % 4));
        if (sz == 2) return 4'(3 << ((int'(a % 4) / 2) * 2));
        return 4'd15;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = size_of(f3);
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // One complete access: IDLE detect, BUSY wait cycles, DONE check
    task automatic run_access(input bit ld, input bit st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int wait_cyc,
                              input bit err, input bit skip_wait);
        bit is_load = ld & ~st;
        bit trap;
        bit exp_err;
        int exp_busy;
        int stalls = 0;
        logic [31:0] exp_ld;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (a % size_of(f3)) != 0;
`else
        trap = 1'b0;
`endif
        exp_busy = (wait_cyc < TO) ? wait_cyc + 1 : TO;
        exp_err  = err || (wait_cyc >= TO);
        exp_ld   = exp_err ? 32'd0 : exp_load(f3, a, rd);
        if (!skip_wait) begin @(posedge clk); #1; end
        readm = ld; memWrtm = st; funct3m = f3; aluRsltm = a; wrtDm = wd;
        dAck = 1'b0; dErr = 1'b0; dRdata = $urandom;
        #1;
        checks++;
        if (stallm !== 1'b1 || dReq !== 1'b0) begin
            failures++;
            $display("FAIL c0_detect: got stallm=%b dReq=%b exp stallm=1 dReq=0", stallm, dReq);
        end
        if (stallm === 1'b1) stalls++;
        if (trap) begin
            @(posedge clk); #1;
            checks++;
            if (misalignm !== 1'b1 || dReq !== 1'b0 || stallm !== 1'b0 ||
                loadVldm !== 1'b0 || loadDm !== 32'd0 || busErrm !== 1'b0) begin
                failures++;
                $display("FAIL misalign_trap: got mis=%b req=%b stall=%b vld=%b ld=%h err=%b exp 1 0 0 0 0 0",
                         misalignm, dReq, stallm, loadVldm, loadDm, busErrm);
            end
            return;
        end
        for (int k = 0; k < exp_busy; k++) begin
            @(posedge clk); #1;
            if (k == wait_cyc) begin
                dAck = 1'b1; dErr = err; dRdata = rd;
            end else begin
                dAck = 1'b0; dErr = 1'b0; dRdata = $urandom;
            end
            #1;
            checks++;
            if (dReq !== 1'b1 || stallm !== 1'b1 || dWe !== st || dAddr !== (a - a % 4)) begin
                failures++;
                $display("FAIL busy_bus: got req=%b stall=%b we=%b addr=%h exp 1 1 %b %h",
                         dReq, stallm, dWe, dAddr, st, a - a % 4);
            end
            if (st) begin
                checks++;
                if (dBe !== exp_be(f3, a) || dWdata !== exp_wdata(f3, wd)) begin
                    failures++;
                    $display("FAIL store_lanes: got be=%b wdata=%h exp be=%b wdata=%h",
                             dBe, dWdata, exp_be(f3, a), exp_wdata(f3, wd));
                end
            end
            if (stallm === 1'b1) stalls++;
        end
        @(posedge clk); #1;
        dAck = 1'b0; dErr = 1'b0;
        #1;
        checks++;
        if (stallm !== 1'b0 || dReq !== 1'b0 || busErrm !== exp_err ||
            loadVldm !== is_load || misalignm !== 1'b0) begin
            failures++;
            $display("FAIL done_flags: got stall=%b req=%b err=%b vld=%b mis=%b exp 0 0 %b %b 0",
                     stallm, dReq, busErrm, loadVldm, misalignm, exp_err, is_load);
        end
        if (is_load) begin
            checks++;
            if (loadDm !== exp_ld) begin
                failures++;
                $display("FAIL load_data: got %h exp %h (f3=%b addr=%h rd=%h)", loadDm, exp_ld, f3, a, rd);
            end
        end
        checks++;
        if (stalls != exp_busy + 1) begin
            failures++;
            $display("FAIL stall_cycles: got %0d exp %0d", stalls, exp_busy + 1);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        readm = 1'b0; memWrtm = 1'b0; funct3m = 3'($urandom); aluRsltm = $urandom;
        dAck = 1'($urandom); dErr = 1'($urandom);
        #1;
        checks++;
        if (stallm !== 1'b0 || dReq !== 1'b0 || loadVldm !== 1'b0 || busErrm !== 1'b0 || misalignm !== 1'b0) begin
            failures++;
            $display("FAIL idle: got stall=%b req=%b vld=%b err=%b mis=%b exp all 0",
                     stallm, dReq, loadVldm, busErrm, misalignm);
        end
        dAck = 1'b0; dErr = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        readm = 1'b1;
        #2;
        checks++;
        if ({stallm, dReq, dWe, loadVldm, busErrm, misalignm} !== 6'd0 ||
            dAddr !== 32'd0 || dWdata !== 32'd0 || dBe !== 4'd0 || loadDm !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: got stall=%b req=%b addr=%h wdata=%h be=%b ld=%h exp all 0",
                     stallm, dReq, dAddr, dWdata, dBe, loadDm);
        end
        @(posedge clk); #1;
        readm = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_nonmem();
        for (int i = 0; i < 4; i++) idle_cycle();
    endtask

    task automatic test_lb();
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, 1'b0, 1'b0);
    endtask

    task automatic test_sh();
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 3, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'd0, 32'h8001_7FFF, 0, 1'b0, 1'b0);
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'd0, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'h1111_2222, 100, 1'b0, 1'b0);
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_5001, 32'd0, 32'h3333_4444, 1, 1'b1, 1'b0);
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_5008, 32'h5555_6666, 32'd0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        readm = 1'b1; memWrtm = 1'b0; funct3m = 3'b010; aluRsltm = 32'h0000_6004;
        @(posedge clk); #1;
        checks++;
        if (dReq !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_busy: got dReq=%b exp 1", dReq);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dReq !== 1'b0 || stallm !== 1'b0 || dAddr !== 32'd0 || loadVldm !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: got req=%b stall=%b addr=%h vld=%b exp 0 0 0 0",
                     dReq, stallm, dAddr, loadVldm);
        end
        #1 rst_n = 1'b1;
        #1;
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'd0, 32'h0BAD_BEEF, 0, 1'b0, 1'b1);
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'd0, 32'h7654_3210, 1, 1'b0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_random();
        logic [2:0] f3s [8];
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 40; i++) begin
            int kind = $urandom_range(0, 2);
            run_access(kind != 1, kind != 0, f3s[$urandom_range(0, 7)], $urandom, $urandom,
                       $urandom, $urandom_range(0, 5), $urandom_range(0, 7) == 0, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nonmem();
        test_lb();
        test_sh();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_misalign();
        test_random();
        idle_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
